// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser followed by a stability-counter
// FSM that only follows a new level once it has held for STABLE_CYCLES samples.
module button_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic db,
    output logic settling
);

    typedef enum logic [1:0] {
        LOW    = 2'b00,
        WAIT_H = 2'b01,
        HIGH   = 2'b10,
        WAIT_L = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Synchroniser stage: btn is asynchronous, only s2 is safe to decide on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Qualification stage: db and settling are registered alongside the state
    // so they always match the decode of the current state without glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOW;
            cnt      <= '0;
            db       <= 1'b0;
            settling <= 1'b0;
        end else begin
            case (state)
                LOW: begin
                    if (s2) begin
                        state    <= WAIT_H;
                        cnt      <= '0;
                        settling <= 1'b1;
                    end
                end
                WAIT_H: begin
                    // The level check comes first, so an abort beats terminal count
                    if (!s2) begin
                        state    <= LOW;
                        cnt      <= '0;
                        settling <= 1'b0;
                    end else if (cnt == LAST) begin
                        state    <= HIGH;
                        cnt      <= '0;
                        db       <= 1'b1;
                        settling <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state    <= WAIT_L;
                        cnt      <= '0;
                        settling <= 1'b1;
                    end
                end
                WAIT_L: begin
                    if (s2) begin
                        state    <= HIGH;
                        cnt      <= '0;
                        settling <= 1'b0;
                    end else if (cnt == LAST) begin
                        state    <= LOW;
                        cnt      <= '0;
                        db       <= 1'b0;
                        settling <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= LOW;
                    cnt      <= '0;
                    db       <= 1'b0;
                    settling <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: a run-length reference model pushes the expected
// {db, settling} each clock edge; the monitor pops and compares on the falling edge.
module tb_button_debouncer;

    localparam int N     = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn = 1'b0;
    logic db;
    logic settling;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];
    logic [1:0] sb_exp;

    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    logic m_db = 1'b0;
    int   m_run = 0;

    button_debouncer #(
        .STABLE_CYCLES(N),
        .CNT_W        (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .db      (db),
        .settling(settling)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Length of the current run of samples that disagree with the debounced level
    function automatic int run_next(input logic s2v, input logic dbv, input int run);
        return (s2v != dbv) ? run + 1 : 0;
    endfunction

    // Reference: db flips once N+1 consecutive synchronised samples disagree with it
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1  <= 1'b0;
            m_s2  <= 1'b0;
            m_db  <= 1'b0;
            m_run <= 0;
            exp_q.delete();
        end else begin
            m_s1 <= btn;
            m_s2 <= m_s1;
            if (run_next(m_s2, m_db, m_run) == N + 1) begin
                m_db  <= ~m_db;
                m_run <= 0;
                exp_q.push_back({~m_db, 1'b0});
            end else begin
                m_run <= run_next(m_s2, m_db, m_run);
                exp_q.push_back({m_db, run_next(m_s2, m_db, m_run) != 0});
            end
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            check_val("db", {31'd0, db}, {31'd0, sb_exp[1]});
            check_val("settling", {31'd0, settling}, {31'd0, sb_exp[0]});
        end
    end

    // Called at falling edge + 1; holds btn for n rising edges.
    task automatic drive(input logic b, input int n);
        btn = b;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        check_val({tag, "_db"}, {31'd0, db}, 32'd0);
        check_val({tag, "_settling"}, {31'd0, settling}, 32'd0);
        check_val({tag, "_cnt"}, 32'(dut.cnt), 32'd0);
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1;
        async_reset("por");
        drive(1'b0, 3);

        // Clean press, then reset while HIGH with btn still held
        drive(1'b1, 10);
        check_val("press_high", {31'd0, db}, 32'd1);
        async_reset("rst_high");
        drive(1'b1, 12);
        check_val("relatch_high", {31'd0, db}, 32'd1);

        // Clean release
        drive(1'b0, 10);
        check_val("release_low", {31'd0, db}, 32'd0);

        // Pure bounce: too short to qualify
        drive(1'b1, 3);
        drive(1'b0, 8);
        check_val("bounce_low", {31'd0, db}, 32'd0);

        // Bounce then settle
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 10);
        check_val("settle_high", {31'd0, db}, 32'd1);

        // Release with a 2-cycle glitch back to 1 during WAIT_L
        drive(1'b0, 3);
        drive(1'b1, 2);
        drive(1'b0, 10);
        check_val("glitch_release_low", {31'd0, db}, 32'd0);

        // Reset while qualifying a press at cnt=2
        drive(1'b1, 5);
        check_val("midwait_cnt", 32'(dut.cnt), 32'd2);
        async_reset("rst_wait");
        drive(1'b1, 12);
        check_val("post_rst_high", {31'd0, db}, 32'd1);

        // Random bouncing segments
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
        end
        drive(1'b0, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Front-end conditioning stage for a raw mechanical push-button. Synchronises the asynchronous input into the clock domain and filters contact bounce with a stability counter. Produces a clean debounced level `db` that drives the `w` input of the downstream rising-edge detector, so each physical press yields exactly one edge pulse.

## Interface
- `STABLE_CYCLES`, 16: number of consecutive cycles the synchronised input must hold a new level before `db` follows it; legal range 2 .. 2^`CNT_W`.
- `CNT_W`, 8: width of the stability counter.
- `clk`  input  1  system clock, all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high; clears all state immediately.
- `btn`  input  1  raw button level, asynchronous to `clk`, may bounce.
- `db`  output  1  debounced level, glitch-free, feeds the edge detector's `w`.
- `settling`  output  1  high while a candidate level change is being qualified.

## Operation
- Synchroniser: two-flop chain `s1 <= btn`, `s2 <= s1`. The FSM sees only `s2`.
- Counter `cnt` is `CNT_W` bits and is cleared on every FSM state entry.
- State register is 2 bits with four states:
  - LOW: `db`=0. If `s2`=1, go to WAIT_H with `cnt`<=0. Otherwise stay.
  - WAIT_H: `db`=0. If `s2`=0, go to LOW (bounce rejected). Else if `cnt`==`STABLE_CYCLES`-1, go to HIGH. Else `cnt`<=`cnt`+1.
  - HIGH: `db`=1. If `s2`=0, go to WAIT_L with `cnt`<=0. Otherwise stay.
  - WAIT_L: `db`=1. If `s2`=1, go to HIGH (bounce rejected). Else if `cnt`==`STABLE_CYCLES`-1, go to LOW. Else `cnt`<=`cnt`+1.
  - Unreachable encoding: go to LOW.
- `db` is decoded from the registered state as (HIGH or WAIT_L), so it has no combinational path from `btn`.
- `settling` = (WAIT_H or WAIT_L).
- Counter arithmetic is unsigned, and `cnt` never exceeds `STABLE_CYCLES`-1, so no wrap-around is possible within the legal parameter range.
- Any single opposite sample of `s2` during WAIT_x aborts qualification. A fresh transition then restarts from `cnt`=0.

## Timing
- Reset values: `s1`=0, `s2`=0, state=LOW, `cnt`=0, `db`=0, `settling`=0.
- Reset takes effect asynchronously, including mid-qualification. Outputs drop to 0 without waiting for a clock edge.
- Clean transition timeline, with E0 the first edge that samples the new `btn` level:
  - E1: `s2` takes the new level.
  - E2: enter WAIT_x with `cnt`=0.
  - E(2+j): `cnt`=j.
  - E(N+2): enter the final state, where N=`STABLE_CYCLES`.
- `db` changes after edge E(N+2), i.e. the (N+3)rd edge counting E0 as the first. `settling` is high for exactly N cycles (after E2 through E(N+1)).
- Pulses on `btn` too short to reach `s2` are ignored entirely. A pulse reaching `s2` for fewer than N+1 consecutive samples never changes `db`.
- Simultaneous abort and terminal count: abort wins, because the `s2` check precedes the `cnt` check.
- After reset release with `btn` already high, full N+3 latency applies before `db`=1.

## Test plan
- Reset: assert `rst` mid-run with `btn`=1 → `db`=0 and `settling`=0 within the same cycle. Both stay 0 until 3 edges after release.
- Clean press, `STABLE_CYCLES`=4: `btn` 0→1 held → `settling`=1 after edges 3–6, `db`=1 after edge 7 and stays high.
- Pure bounce, `STABLE_CYCLES`=4: `btn` high for 3 cycles then low → `settling` pulses, `db` stays 0, FSM returns to LOW.
- Bounce then settle: `btn` toggles 1,0,1,0,1 on successive cycles then holds 1 → `db` rises after the 7th edge following the final 0→1 sample, exactly once.
- Release: from HIGH, `btn` 1→0 held → `db`=0 after edge 7. A 2-cycle 1-glitch during WAIT_L returns to HIGH and restarts qualification.
- Reset mid-WAIT_H: `rst` pulsed at `cnt`=2 with `btn` held 1 → `db`=0 and `cnt`=0 immediately. After release, `db` rises after the 7th edge counted from the first post-reset edge.
